apb_uart_tx: RTL and testbench
==============================

Name: apb_uart_tx

Overview:
APB3 slave UART transmitter. It sits directly downstream of the APB_BUS master, on one PSEL line of the 2-slave bus alongside APB_GPIO. It accepts bytes through memory-mapped registers and buffers them in a small FIFO. It serialises them on TXD as 8N1 frames at a programmable baud divisor, raising a level interrupt when transmission drains.

Parameters:
DATA_WIDTH, 32, APB data bus width (PWDATA/PRDATA).
ADDRESS_WIDTH, 4, APB address width; byte address, 4 word registers.
STRB_WIDTH, 4, PSTRB width (DATA_WIDTH/8).
FIFO_DEPTH, 8, TX FIFO entries; power of two, >=2.
DIV_RESET, 16, reset value of BAUDDIV.

Ports:
PCLK  input  1  bus clock; all state on rising edge.
PRESETn  input  1  asynchronous, active-low reset.
PSEL  input  1  this slave's select bit from APB_BUS PSEL vector.
PENABLE  input  1  APB access phase.
PADDR  input  ADDRESS_WIDTH  byte address.
PWRITE  input  1  1=write, 0=read.
PWDATA  input  DATA_WIDTH  write data.
PSTRB  input  STRB_WIDTH  write byte strobes.
PRDATA  output  DATA_WIDTH  read data; valid when PSEL&PENABLE&PREADY.
PREADY  output  1  transfer completion / wait-state insertion.
PSLVERR  output  1  error response; valid only with PREADY=1 in access phase.
TXD  output  1  serial line, idle high.
IRQ  output  1  level interrupt.

Behaviour:
- Reset (PRESETn=0, async): TXD=1, IRQ=0, PSLVERR=0, PREADY=1, PRDATA=0; FIFO empty; FSM=IDLE; CTRL=0; BAUDDIV=DIV_RESET.
- Register map (PADDR[3:2]):
  - 0x0 TXDATA: W pushes PWDATA[7:0] when PSTRB[0]=1. Reads 0.
  - 0x4 STATUS: RO. bit0 full, bit1 empty, bit2 busy (FSM!=IDLE), bits[7:4] FIFO count; rest 0.
  - 0x8 CTRL: bit0 tx_en, bit1 irq_en; byte-lane writes honour PSTRB.
  - 0xC BAUDDIV: [15:0], per PSTRB[1:0]; value 0 treated as 1.
- PADDR[1:0]!=0, or a write to STATUS: PSLVERR=1, PREADY=1, no state change.
- Setup phase (PSEL=1, PENABLE=0): no effect.
- Access phase completes in the same cycle (zero wait), with these exceptions for a TXDATA write when the FIFO is full:
  - tx_en=1: PREADY=0 (wait states) until count<FIFO_DEPTH. The push occurs in the first cycle PREADY=1. The FIFO pop frees space one cycle before PREADY rises (count is registered).
  - tx_en=0: PREADY=1, PSLVERR=1, byte dropped.
- PRDATA combinational from registers during read access; 0 otherwise.
- Push with PSTRB[0]=0: no push, OKAY response.
- FIFO: count range 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH. Simultaneous push+pop leaves count unchanged.
- TX FSM states IDLE, START, DATA, STOP. Bit time = BAUDDIV cycles; a bit counter counts 0..7 in DATA.
  - IDLE -> START when tx_en=1 and FIFO non-empty. Pop into the shift register on that edge; TXD=0 from the next cycle.
  - START -> DATA after 1 bit time; LSB first.
  - DATA -> STOP after bit 7's bit time; TXD=1.
  - STOP -> START after 1 bit time if tx_en & non-empty (back-to-back, no idle gap); else -> IDLE.
- Frame = 10*BAUDDIV cycles.
- tx_en cleared mid-frame: the current frame completes, then the FSM holds IDLE; FIFO contents are retained.
- BAUDDIV written mid-frame: takes effect at the next bit boundary.
- IRQ registered = irq_en & empty & !busy; asserts 1 cycle after the FSM returns to IDLE with an empty FIFO.
- Reset mid-frame: TXD returns to 1 immediately; the FIFO is flushed.

Test Plan:
- Reset, then read 0x4 and 0xC -> STATUS=0x0000_0002 (empty), BAUDDIV=16, TXD=1, IRQ=0, every access PREADY=1 in its first access cycle.
- BAUDDIV=4, CTRL=0x1, write TXDATA=0xA5 -> TXD low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high. Frame 40 cycles; STATUS.busy=1 during it.
- CTRL=0x0, write 8 bytes 0x00..0x07 -> count=8, full=1. 9th write -> PSLVERR=1, PREADY=1, count stays 8.
- Set CTRL=0x1 with FIFO full, then write 0x55 -> PREADY low until the first pop frees a slot, then completes OKAY. All 9 bytes are sent back-to-back with no idle gap between stop and start.
- CTRL=0x3, send 1 byte -> IRQ=1 one cycle after the stop bit ends. Writing CTRL=0x1 -> IRQ=0.
- Access to PADDR=0x5 and write to 0x4 -> PSLVERR=1, registers unchanged. Assert PRESETn mid-DATA -> TXD=1 at once, STATUS=0x2 after release.

Source files
------------

// File: rtl/apb_uart_tx.sv
// APB3 UART transmitter: buffers bytes in a TX FIFO and sends them on TXD as 8N1 frames; zero-wait registers.
// A TXDATA write to a full FIFO inserts wait states while tx_en=1, otherwise completes with PSLVERR and drops the byte.

module uart_tx_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             core_clk,
  input  logic             arst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic [AW:0]      cnt,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign full   = (cnt == (AW+1)'(DEPTH));
  assign empty  = (cnt == '0);
  assign do_wr  = wr_vld & ~full;
  assign do_rd  = rd_rdy & ~empty;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge core_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module apb_uart_tx #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4,
  parameter int STRB_WIDTH    = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int DIV_RESET     = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic [ADDRESS_WIDTH-1:0] PADDR,
  input  logic                     PWRITE,
  input  logic [DATA_WIDTH-1:0]    PWDATA,
  input  logic [STRB_WIDTH-1:0]    PSTRB,
  output logic [DATA_WIDTH-1:0]    PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  output logic                     TXD,
  output logic                     IRQ
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  tx_state_t       state, state_nxt;
  logic            acc, addr_ok, reg_wr, txdata_wr, stall, drop, push, bad_acc;
  logic [1:0]      reg_sel;
  logic            tx_en, irq_en;
  logic [15:0]     baud_div, div_eff, div_lat, div_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift, fifo_dat;
  logic [CW-1:0]   fifo_cnt;
  logic [3:0]      cnt4;
  logic            fifo_full, fifo_empty, pop, start_ok, bit_end, busy, txd_c;
  logic            unused_ok;

  assign acc       = PSEL & PENABLE;
  assign addr_ok   = (PADDR[1:0] == 2'b00);
  assign reg_sel   = PADDR[3:2];
  assign reg_wr    = acc & PWRITE & addr_ok;
  assign txdata_wr = reg_wr & (reg_sel == 2'd0) & PSTRB[0];
  assign stall     = txdata_wr & fifo_full & tx_en;
  assign drop      = txdata_wr & fifo_full & ~tx_en;
  assign push      = txdata_wr & ~fifo_full;
  assign bad_acc   = acc & (~addr_ok | (PWRITE & (reg_sel == 2'd1)));
  assign PREADY    = ~stall;
  assign PSLVERR   = bad_acc | drop;
  assign unused_ok = ^{PWDATA[DATA_WIDTH-1:16], PSTRB[STRB_WIDTH-1:2]};

  uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .core_clk (PCLK),
    .arst_n   (PRESETn),
    .wr_vld   (push),
    .wr_dat   (PWDATA[7:0]),
    .rd_rdy   (pop),
    .rd_dat   (fifo_dat),
    .cnt      (fifo_cnt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_en    <= 1'b0;
      irq_en   <= 1'b0;
      baud_div <= 16'(DIV_RESET);
    end else begin
      if (reg_wr && reg_sel == 2'd2 && PSTRB[0]) begin
        tx_en  <= PWDATA[0];
        irq_en <= PWDATA[1];
      end
      if (reg_wr && reg_sel == 2'd3) begin
        if (PSTRB[0]) baud_div[7:0]  <= PWDATA[7:0];
        if (PSTRB[1]) baud_div[15:8] <= PWDATA[15:8];
      end
    end
  end

  assign busy = (state != IDLE);
  assign cnt4 = 4'(fifo_cnt);

  always_comb begin
    PRDATA = '0;
    if (acc && !PWRITE && addr_ok) begin
      case (reg_sel)
        2'd1:    PRDATA[7:0]  = {cnt4, 1'b0, busy, fifo_empty, fifo_full};
        2'd2:    PRDATA[1:0]  = {irq_en, tx_en};
        2'd3:    PRDATA[15:0] = baud_div;
        default: PRDATA = '0;
      endcase
    end
  end

  // Divisor is latched per bit so a BAUDDIV write only lands on a bit boundary.
  assign div_eff  = (baud_div == 16'd0) ? 16'd1 : baud_div;
  assign bit_end  = (div_cnt == div_lat - 16'd1);
  assign start_ok = tx_en & ~fifo_empty;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && bit_cnt == 3'd7) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = start_ok ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop   = 1'b0;
    txd_c = 1'b1;
    case (state)
      IDLE:    pop = start_ok;
      START:   txd_c = 1'b0;
      DATA:    txd_c = shift[0];
      STOP:    pop = bit_end & start_ok;
      default: txd_c = 1'b1;
    endcase
  end

  assign TXD = txd_c;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      div_cnt <= '0;
      div_lat <= 16'd1;
      bit_cnt <= '0;
      shift   <= 8'hFF;
    end else begin
      if (busy && !bit_end) begin
        div_cnt <= div_cnt + 16'd1;
      end else begin
        div_cnt <= '0;
        div_lat <= div_eff;
      end
      if (pop)                         shift <= fifo_dat;
      else if (state == DATA && bit_end) shift <= {1'b1, shift[7:1]};
      if (state == START)                bit_cnt <= '0;
      else if (state == DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) IRQ <= 1'b0;
    else          IRQ <= irq_en & fifo_empty & ~busy;
  end
endmodule

// File: tb/tb_apb_uart_tx.sv
// Bench for apb_uart_tx: register vector table, timed corner sequences, and random traffic
// checked by a line-level UART receiver against a queue-based byte model.
module tb_apb_uart_tx;
  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR, TXD, IRQ;

  apb_uart_tx dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .TXD(TXD), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  initial begin
    #900000;
    $display("FAIL watchdog: run still going at cycle %0d, want finished", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- line receiver: decodes frames at the current divisor ----------------
  typedef struct { logic [7:0] b; int s; } frame_t;
  frame_t      rxq[$];
  bit          rx_en;
  int          rx_div;
  int          rx_d, rx_s;
  logic [9:0]  rx_bits;
  bit          rx_bad, rx_abort;

  initial begin
    forever begin
      @(negedge PCLK);
      if (rx_en && PRESETn === 1'b1 && TXD === 1'b0) begin
        rx_d = rx_div; rx_s = cyc; rx_bad = 0; rx_abort = 0; rx_bits = '0;
        for (int i = 0; i < 10; i++) begin
          for (int k = 0; k < rx_d; k++) begin
            if (i != 0 || k != 0) @(negedge PCLK);
            if (!rx_en || PRESETn !== 1'b1) rx_abort = 1;
            if (k == 0) rx_bits[i] = TXD;
            else if (TXD !== rx_bits[i]) rx_bad = 1;
          end
        end
        if (!rx_abort) begin
          n_vec++;
          if (rx_bad || rx_bits[0] !== 1'b0 || rx_bits[9] !== 1'b1) begin
            n_err++;
            $display("FAIL frame_shape at cycle %0d: bits %b unstable=%0d, want start 0, stop 1, each bit %0d cycles",
                     rx_s, rx_bits, rx_bad, rx_d);
          end
          rxq.push_back('{rx_bits[8:1], rx_s});
        end
      end
    end
  end

  task automatic wait_rx(input int n, input int budget);
    int t = 0;
    while (rxq.size() < n && t < budget) begin
      @(negedge PCLK);
      t++;
    end
    if (rxq.size() < n) chk("rx_timeout_frames", rxq.size(), n);
  endtask

  // ---------------- APB master ----------------
  task automatic apb(input bit wr, input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] st,
                     output logic [31:0] rd, output bit err, output int waits, output int done);
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wd; PSTRB = st;
    @(posedge PCLK); #1;
    PENABLE = 1;
    waits = 0;
    @(negedge PCLK);
    while (!PREADY && waits <= 2000) begin
      waits++;
      @(negedge PCLK);
    end
    if (!PREADY) chk("apb_pready_timeout", PREADY, 1);
    rd = PRDATA; err = PSLVERR; done = cyc;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  logic [31:0] a_rd;
  bit          a_err;
  int          a_w, a_done;

  task automatic wr(input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] st);
    apb(1'b1, addr, wd, st, a_rd, a_err, a_w, a_done);
  endtask

  task automatic rd(input logic [3:0] addr, output logic [31:0] d);
    apb(1'b0, addr, 32'h0, 4'h0, d, a_err, a_w, a_done);
  endtask

  // ---------------- register vector table ----------------
  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t vt[$];

  logic [31:0] r_rd, r_wd;
  logic [3:0]  r_st;
  logic [15:0] bd_m;
  logic [7:0]  expq[$];
  int          d66, w66, gaps, irq_cyc, n_rnd;

  initial begin
    PRESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; PSTRB = 0;
    rx_en = 0; rx_div = 16;
    repeat (3) @(negedge PCLK);
    chk("rst_txd", TXD, 1);
    chk("rst_irq", IRQ, 0);
    chk("rst_pready", PREADY, 1);
    chk("rst_pslverr", PSLVERR, 0);
    chk("rst_prdata", PRDATA, 0);
    PRESETn = 1;
    rx_en = 1;

    vt.push_back('{0, 4'h4, 32'h0,         4'h0, 32'h0000_0002, 0});
    vt.push_back('{0, 4'hC, 32'h0,         4'h0, 32'h0000_0010, 0});
    vt.push_back('{0, 4'h8, 32'h0,         4'h0, 32'h0000_0000, 0});
    vt.push_back('{1, 4'hC, 32'h1234_0005, 4'h1, 32'h0,         0});
    vt.push_back('{0, 4'hC, 32'h0,         4'h0, 32'h0000_0005, 0});
    vt.push_back('{1, 4'hC, 32'h0000_AB77, 4'h2, 32'h0,         0});
    vt.push_back('{0, 4'hC, 32'h0,         4'h0, 32'h0000_AB05, 0});
    vt.push_back('{1, 4'h8, 32'h0000_00FF, 4'h0, 32'h0,         0});
    vt.push_back('{0, 4'h8, 32'h0,         4'h0, 32'h0000_0000, 0});
    vt.push_back('{1, 4'h8, 32'h0000_0002, 4'h1, 32'h0,         0});
    vt.push_back('{0, 4'h8, 32'h0,         4'h0, 32'h0000_0002, 0});
    vt.push_back('{0, 4'h5, 32'h0,         4'h0, 32'h0,         1});
    vt.push_back('{1, 4'h4, 32'hFFFF_FFFF, 4'hF, 32'h0,         1});
    vt.push_back('{0, 4'h4, 32'h0,         4'h0, 32'h0000_0002, 0});
    vt.push_back('{1, 4'h0, 32'h0000_0011, 4'h0, 32'h0,         0});
    vt.push_back('{0, 4'h4, 32'h0,         4'h0, 32'h0000_0002, 0});
    vt.push_back('{0, 4'h0, 32'h0,         4'h0, 32'h0000_0000, 0});
    vt.push_back('{1, 4'h9, 32'h0000_0003, 4'hF, 32'h0,         1});
    vt.push_back('{0, 4'h8, 32'h0,         4'h0, 32'h0000_0002, 0});
    vt.push_back('{1, 4'h8, 32'h0,         4'h1, 32'h0,         0});
    vt.push_back('{0, 4'h8, 32'h0,         4'h0, 32'h0000_0000, 0});

    foreach (vt[i]) begin
      apb(vt[i].wr, vt[i].addr, vt[i].wd, vt[i].st, a_rd, a_err, a_w, a_done);
      chk($sformatf("vec%0d_err_wait", i), {a_err, a_w[30:0]}, {vt[i].exp_err, 31'd0});
      if (!vt[i].exp_err) chk($sformatf("vec%0d_prdata", i), a_rd, vt[i].exp_rd);
    end

    // Single 0xA5 frame at divisor 4.
    wr(4'hC, 32'd4, 4'h3);
    rx_div = 4;
    wr(4'h8, 32'h1, 4'hF);
    rxq.delete();
    apb(1'b1, 4'h0, 32'hA5, 4'h1, a_rd, a_err, a_w, a_done);
    r_wd = a_done;
    rd(4'h4, r_rd);
    chk("status_busy_in_frame", r_rd, 32'h6);
    wait_rx(1, 200);
    if (rxq.size() >= 1) begin
      chk("a5_byte", rxq[0].b, 8'hA5);
      chk("a5_start_latency", rxq[0].s - r_wd, 2);
    end
    repeat (4) @(negedge PCLK);
    rd(4'h4, r_rd);
    chk("status_after_a5", r_rd, 32'h2);

    // Fill FIFO with transmitter disabled, then overflow.
    wr(4'h8, 32'h0, 4'hF);
    for (int b = 0; b < 8; b++) wr(4'h0, b, 4'h1);
    rd(4'h4, r_rd);
    chk("status_full", r_rd, 32'h81);
    apb(1'b1, 4'h0, 32'h08, 4'h1, a_rd, a_err, a_w, a_done);
    chk("overflow_resp", {a_err, a_w[30:0]}, {1'b1, 31'd0});
    rd(4'h4, r_rd);
    chk("status_full_kept", r_rd, 32'h81);

    // Enable: 0x55 fits after the first pop, 0x66 stalls until the next one.
    rxq.delete();
    wr(4'h8, 32'h1, 4'hF);
    apb(1'b1, 4'h0, 32'h55, 4'h1, a_rd, a_err, a_w, a_done);
    chk("w55_resp", {a_err, a_w[30:0]}, {1'b0, 31'd0});
    apb(1'b1, 4'h0, 32'h66, 4'h1, a_rd, a_err, w66, d66);
    chk("w66_err", a_err, 0);
    chk("w66_stalled", w66 > 0, 1);
    wait_rx(10, 600);
    if (rxq.size() >= 10) begin
      expq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h55, 8'h66};
      foreach (expq[i]) chk($sformatf("burst_byte%0d", i), rxq[i].b, expq[i]);
      chk("w66_release_cycle", d66, rxq[1].s);
      gaps = 0;
      for (int i = 1; i < 10; i++) if (rxq[i].s - rxq[i-1].s != 40) gaps++;
      chk("burst_back_to_back", gaps, 0);
    end

    // Interrupt on drain.
    repeat (4) @(negedge PCLK);
    rxq.delete();
    wr(4'h8, 32'h0, 4'hF);
    wr(4'h0, 32'h3C, 4'h1);
    wr(4'h8, 32'h3, 4'hF);
    irq_cyc = -1;
    for (int t = 0; t < 200 && irq_cyc < 0; t++) begin
      @(negedge PCLK);
      if (IRQ === 1'b1) irq_cyc = cyc;
    end
    wait_rx(1, 10);
    if (rxq.size() >= 1) begin
      chk("irq_byte", rxq[0].b, 8'h3C);
      chk("irq_rise_cycle", irq_cyc, rxq[0].s + 41);
    end
    wr(4'h8, 32'h1, 4'hF);
    @(posedge PCLK);
    @(negedge PCLK);
    chk("irq_clear", IRQ, 0);

    // Reset in the middle of DATA bits.
    rx_en = 0;
    wr(4'h8, 32'h0, 4'hF);
    wr(4'hC, 32'd8, 4'h3);
    for (int b = 0; b < 3; b++) wr(4'h0, 32'h0, 4'h1);
    wr(4'h8, 32'h1, 4'hF);
    repeat (30) @(negedge PCLK);
    chk("pre_reset_txd_low", TXD, 0);
    PRESETn = 0;
    #1;
    chk("reset_txd_async", TXD, 1);
    @(negedge PCLK);
    PRESETn = 1;
    rd(4'h4, r_rd);
    chk("post_reset_status", r_rd, 32'h2);
    rd(4'hC, r_rd);
    chk("post_reset_bauddiv", r_rd, 32'd16);
    rd(4'h8, r_rd);
    chk("post_reset_ctrl", r_rd, 32'h0);

    // Random traffic against queue model.
    rx_en = 1;
    bd_m = 16'd16;
    for (int r = 0; r < 4; r++) begin
      rxq.delete();
      expq.delete();
      r_wd = $urandom_range(0, 5);
      r_st = 4'($urandom_range(1, 3));
      if (r_st[0]) bd_m[7:0]  = r_wd[7:0];
      if (r_st[1]) bd_m[15:8] = r_wd[15:8];
      wr(4'hC, r_wd, r_st);
      rd(4'hC, r_rd);
      chk($sformatf("rnd%0d_bauddiv", r), r_rd, {16'h0, bd_m});
      rx_div = (bd_m == 16'd0) ? 1 : int'(bd_m);
      wr(4'h8, 32'h1, 4'hF);
      n_rnd = $urandom_range(4, 14);
      for (int i = 0; i < n_rnd; i++) begin
        r_wd = $urandom;
        r_st = 4'($urandom);
        if (r_st[0]) expq.push_back(r_wd[7:0]);
        apb(1'b1, 4'h0, r_wd, r_st, a_rd, a_err, a_w, a_done);
        chk($sformatf("rnd%0d_push%0d_err", r, i), a_err, 0);
      end
      wait_rx(expq.size(), expq.size() * 10 * rx_div + 400);
      if (rxq.size() == expq.size())
        foreach (expq[i]) chk($sformatf("rnd%0d_byte%0d", r, i), rxq[i].b, expq[i]);
      else
        chk($sformatf("rnd%0d_frame_count", r), rxq.size(), expq.size());
      repeat (5) @(negedge PCLK);
      rd(4'h4, r_rd);
      chk($sformatf("rnd%0d_status_idle", r), r_rd, 32'h2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
